reg_demux_tmo: RTL and testbench

- Parametrised register-bus demultiplexer for the peripheral subsystem. It sits between the AXI-to-reg converter and the register slaves.
- Decodes the request address against a runtime base/mask map and forwards the request to exactly one slave port.
- Unmapped addresses are answered by an internal error responder.
- A per-transaction watchdog terminates hung slaves with an error response and records a sticky status.

---
 rtl/reg_demux_tmo.sv | 187 ++++++++++++++++++
 tb/tb_reg_demux_tmo.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_demux_tmo.sv
// Register-bus demultiplexer: decodes a runtime base/mask map, forwards each request
// to one slave port, answers unmapped addresses itself and times out hung slaves.
module reg_demux_tmo #(
  parameter int          NumPorts      = 4,
  parameter int          AddrWidth     = 32,
  parameter int          DataWidth     = 32,
  parameter int          TimeoutCycles = 256,
  parameter logic [31:0] ErrData       = 32'hBADCAB1E,
  parameter int          SelW          = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           in_valid_i,
  input  logic                           in_write_i,
  input  logic [AddrWidth-1:0]           in_addr_i,
  input  logic [DataWidth-1:0]           in_wdata_i,
  input  logic [DataWidth/8-1:0]         in_wstrb_i,
  output logic                           in_ready_o,
  output logic [DataWidth-1:0]           in_rdata_o,
  output logic                           in_error_o,
  input  logic [NumPorts*AddrWidth-1:0]  addr_base_i,
  input  logic [NumPorts*AddrWidth-1:0]  addr_mask_i,
  output logic [NumPorts-1:0]            out_valid_o,
  output logic                           out_write_o,
  output logic [AddrWidth-1:0]           out_addr_o,
  output logic [DataWidth-1:0]           out_wdata_o,
  output logic [DataWidth/8-1:0]         out_wstrb_o,
  input  logic [NumPorts-1:0]            out_ready_i,
  input  logic [NumPorts*DataWidth-1:0]  out_rdata_i,
  input  logic [NumPorts-1:0]            out_error_i,
  output logic                           tmo_o,
  output logic [SelW-1:0]                tmo_port_o,
  input  logic                           tmo_clr_i
);

  localparam int StrbW = DataWidth / 8;
  localparam int CntW  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0]      CntMax   = CntW'(TimeoutCycles);
  localparam logic [DataWidth-1:0] ErrDataW = DataWidth'(ErrData);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FWD  = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]           state_r;
  logic [SelW-1:0]      sel_r;
  logic [CntW-1:0]      cnt_r;
  logic                 hit_s;
  logic [SelW-1:0]      dec_sel_s;
  logic [NumPorts-1:0]  dec_onehot_s;
  logic                 port_ready_s;
  logic                 port_error_s;
  logic [DataWidth-1:0] port_rdata_s;
  logic [CntW-1:0]      cnt_inc_s;
  logic                 tmo_hit_s;

  // Address decode; scanning downwards leaves the lowest matching port selected.
  always_comb begin
    hit_s        = 1'b0;
    dec_sel_s    = {SelW{1'b0}};
    dec_onehot_s = {NumPorts{1'b0}};
    for (int p = NumPorts - 1; p >= 0; p--) begin
      if ((in_addr_i & addr_mask_i[p*AddrWidth +: AddrWidth]) ==
          (addr_base_i[p*AddrWidth +: AddrWidth] & addr_mask_i[p*AddrWidth +: AddrWidth])) begin
        hit_s           = 1'b1;
        dec_sel_s       = SelW'(p);
        dec_onehot_s    = {NumPorts{1'b0}};
        dec_onehot_s[p] = 1'b1;
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Response signals of the currently selected port.
  always_comb begin
    port_ready_s = 1'b0;
    port_error_s = 1'b0;
    port_rdata_s = {DataWidth{1'b0}};
    for (int p = 0; p < NumPorts; p++) begin
      if (sel_r == SelW'(p)) begin
        port_ready_s = out_ready_i[p];
        port_error_s = out_error_i[p];
        port_rdata_s = out_rdata_i[p*DataWidth +: DataWidth];
      end else begin
        port_ready_s = port_ready_s;
      end
    end
  end

  // Saturating watchdog increment; a same-cycle ready beats the timeout.
  always_comb begin
    if (cnt_r == CntMax) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + CntW'(1);
    end
    tmo_hit_s = (TimeoutCycles > 0) && !port_ready_s && (cnt_inc_s == CntMax);
  end

  // Transaction FSM with registered request fields and response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= S_IDLE;
      sel_r       <= {SelW{1'b0}};
      cnt_r       <= {CntW{1'b0}};
      in_ready_o  <= 1'b0;
      in_rdata_o  <= {DataWidth{1'b0}};
      in_error_o  <= 1'b0;
      out_valid_o <= {NumPorts{1'b0}};
      out_write_o <= 1'b0;
      out_addr_o  <= {AddrWidth{1'b0}};
      out_wdata_o <= {DataWidth{1'b0}};
      out_wstrb_o <= {StrbW{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          in_ready_o <= 1'b0;
          if (in_valid_i) begin
            out_write_o <= in_write_i;
            out_addr_o  <= in_addr_i;
            out_wdata_o <= in_wdata_i;
            out_wstrb_o <= in_wstrb_i;
            sel_r       <= dec_sel_s;
            cnt_r       <= {CntW{1'b0}};
            if (hit_s) begin
              out_valid_o <= dec_onehot_s;
              state_r     <= S_FWD;
            end else begin
              state_r <= S_ERR;
            end
          end
        end
        S_FWD: begin
          if (port_ready_s) begin
            out_valid_o <= {NumPorts{1'b0}};
            in_rdata_o  <= port_rdata_s;
            in_error_o  <= port_error_s;
            in_ready_o  <= 1'b1;
            state_r     <= S_RESP;
          end else if (tmo_hit_s) begin
            out_valid_o <= {NumPorts{1'b0}};
            in_rdata_o  <= ErrDataW;
            in_error_o  <= 1'b1;
            in_ready_o  <= 1'b1;
            state_r     <= S_RESP;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        S_ERR: begin
          in_rdata_o <= ErrDataW;
          in_error_o <= 1'b1;
          in_ready_o <= 1'b1;
          state_r    <= S_RESP;
        end
        S_RESP: begin
          in_ready_o <= 1'b0;
          state_r    <= S_IDLE;
        end
        default: begin
          in_ready_o  <= 1'b0;
          out_valid_o <= {NumPorts{1'b0}};
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky timeout status; clear beats a coincident timeout, first port is kept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_o      <= 1'b0;
      tmo_port_o <= {SelW{1'b0}};
    end else if (tmo_clr_i) begin
      tmo_o      <= 1'b0;
      tmo_port_o <= {SelW{1'b0}};
    end else if ((state_r == S_FWD) && tmo_hit_s && !tmo_o) begin
      tmo_o      <= 1'b1;
      tmo_port_o <= sel_r;
    end else begin
      tmo_o <= tmo_o;
    end
  end

endmodule

// File: tb/tb_reg_demux_tmo.sv
// Randomized bench for reg_demux_tmo against a transaction-level model of decode,
// response latency, watchdog and sticky timeout status.
module tb_reg_demux_tmo;
  localparam int NP  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;
  localparam int SW  = 2;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             in_valid_i, in_write_i;
  logic [AW-1:0]    in_addr_i;
  logic [DW-1:0]    in_wdata_i;
  logic [DW/8-1:0]  in_wstrb_i;
  logic             in_ready_o, in_error_o;
  logic [DW-1:0]    in_rdata_o;
  logic [NP*AW-1:0] addr_base_i, addr_mask_i;
  logic [NP-1:0]    out_valid_o;
  logic             out_write_o;
  logic [AW-1:0]    out_addr_o;
  logic [DW-1:0]    out_wdata_o;
  logic [DW/8-1:0]  out_wstrb_o;
  logic [NP-1:0]    out_ready_i, out_error_i;
  logic [NP*DW-1:0] out_rdata_i;
  logic             tmo_o;
  logic [SW-1:0]    tmo_port_o;
  logic             tmo_clr_i;

  always #5 clk = ~clk;

  reg_demux_tmo #(.NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_write_i(in_write_i), .in_addr_i(in_addr_i),
    .in_wdata_i(in_wdata_i), .in_wstrb_i(in_wstrb_i),
    .in_ready_o(in_ready_o), .in_rdata_o(in_rdata_o), .in_error_o(in_error_o),
    .addr_base_i(addr_base_i), .addr_mask_i(addr_mask_i),
    .out_valid_o(out_valid_o), .out_write_o(out_write_o), .out_addr_o(out_addr_o),
    .out_wdata_o(out_wdata_o), .out_wstrb_o(out_wstrb_o),
    .out_ready_i(out_ready_i), .out_rdata_i(out_rdata_i), .out_error_i(out_error_i),
    .tmo_o(tmo_o), .tmo_port_o(tmo_port_o), .tmo_clr_i(tmo_clr_i)
  );

  int checks_total = 0;
  int checks_passed = 0;

  logic [31:0] base_m [NP];
  logic [31:0] mask_m [NP];
  logic        tmo_exp;
  logic [1:0]  tmo_port_exp;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int model_decode(input logic [31:0] a);
    for (int p = 0; p < NP; p++)
      if ((a & mask_m[p]) == (base_m[p] & mask_m[p])) return p;
    return -1;
  endfunction

  task automatic drive_map();
    for (int p = 0; p < NP; p++) begin
      addr_base_i[p*AW +: AW] = base_m[p];
      addr_mask_i[p*AW +: AW] = mask_m[p];
    end
  endtask

  task automatic slave_noise();
    out_ready_i = 4'($urandom);
    out_error_i = 4'($urandom);
    out_rdata_i = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Called at a negedge with the DUT idle. d: slave ready on its d-th valid cycle (0 = never).
  task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         input logic [3:0] ws, input int d, input logic [31:0] rd,
                         input logic er, input int clr_at, input bit scramble);
    int port, vcyc, exp_resp;
    bit done, tmo_ev;
    logic [NP-1:0] exp_valid;
    port     = model_decode(addr);
    vcyc     = (d >= 1 && d <= TMO) ? d : TMO;
    exp_resp = (port < 0) ? 2 : vcyc + 1;
    drive_map();
    in_valid_i = 1'b1; in_write_i = wr; in_addr_i = addr; in_wdata_i = wd; in_wstrb_i = ws;
    tmo_clr_i  = 1'b0;
    slave_noise();
    done = 1'b0;
    for (int c = 1; c <= TMO + 4 && !done; c++) begin
      @(negedge clk);
      exp_valid = '0;
      if (port >= 0 && c <= vcyc) exp_valid[port] = 1'b1;
      check_eq("out_valid", out_valid_o, exp_valid);
      check_eq("in_ready", in_ready_o, (c == exp_resp));
      check_eq("tmo_status", {tmo_port_o, tmo_o}, {tmo_port_exp, tmo_exp});
      if (c == 1 && port >= 0) begin
        check_eq("out_addr", out_addr_o, addr);
        check_eq("out_write", out_write_o, wr);
        check_eq("out_wdata", out_wdata_o, wd);
        check_eq("out_wstrb", out_wstrb_o, ws);
      end
      if (c == exp_resp) begin
        check_eq("in_rdata", in_rdata_o, (port < 0 || d < 1 || d > TMO) ? 32'hBADCAB1E : rd);
        check_eq("in_error", in_error_o, (port < 0 || d < 1 || d > TMO) ? 1'b1 : er);
        done = 1'b1;
        in_valid_i = 1'b0;
      end
      if (scramble && c == 1) begin
        addr_base_i = {$urandom, $urandom, $urandom, $urandom};
        addr_mask_i = {$urandom, $urandom, $urandom, $urandom};
      end
      slave_noise();
      if (port >= 0) begin
        out_ready_i[port] = (c == d);
        out_rdata_i[port*DW +: DW] = rd;
        out_error_i[port] = er;
      end
      tmo_clr_i = (c == clr_at) && !done;
      tmo_ev = (port >= 0) && (d < 1 || d > TMO) && (c == TMO);
      if (tmo_clr_i) begin
        tmo_exp = 1'b0; tmo_port_exp = 2'd0;
      end else if (tmo_ev && !tmo_exp) begin
        tmo_exp = 1'b1; tmo_port_exp = port[1:0];
      end
    end
    if (!done) check_eq("resp_timeout", 1'b0, 1'b1);
    // bubble cycle before the next request
    @(negedge clk);
    check_eq("ready_drop", in_ready_o, 1'b0);
    check_eq("valid_idle", out_valid_o, 4'b0000);
    tmo_clr_i = 1'b0;
    drive_map();
  endtask

  initial begin
    rst_i = 1'b1; in_valid_i = 1'b0; in_write_i = 1'b0; in_addr_i = '0; in_wdata_i = '0;
    in_wstrb_i = '0; out_ready_i = '0; out_error_i = '0; out_rdata_i = '0; tmo_clr_i = 1'b0;
    base_m = '{32'h1000, 32'h2000, 32'h3000, 32'h4000};
    mask_m = '{32'hF000, 32'hF000, 32'hF000, 32'hFF00};
    drive_map();
    tmo_exp = 1'b0; tmo_port_exp = 2'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", in_ready_o, 1'b0);
    check_eq("rst_rdata", in_rdata_o, 32'h0);
    check_eq("rst_error", in_error_o, 1'b0);
    check_eq("rst_valid", out_valid_o, 4'b0000);
    check_eq("rst_fields", {out_write_o, out_addr_o, out_wdata_o, out_wstrb_o}, 69'h0);
    check_eq("rst_tmo", {tmo_port_o, tmo_o}, 3'b000);
    rst_i = 1'b0;
    @(negedge clk);

    run_txn(32'h2004, 1'b0, 32'h0, 4'h0, 3, 32'hCAFE0001, 1'b0, 0, 1'b0);
    run_txn(32'h1008, 1'b1, 32'h12345678, 4'hF, 1, 32'h0, 1'b0, 0, 1'b0);
    run_txn(32'h9000, 1'b0, 32'h0, 4'h0, 1, 32'h55, 1'b0, 0, 1'b0);
    run_txn(32'h2010, 1'b0, 32'h0, 4'h0, 0, 32'h77, 1'b0, 0, 1'b0);
    // late ready on the timed-out port while idle
    out_ready_i = 4'b0010;
    @(negedge clk);
    check_eq("late_ready_valid", out_valid_o, 4'b0000);
    check_eq("late_ready_resp", in_ready_o, 1'b0);
    out_ready_i = 4'b0000;
    run_txn(32'h1004, 1'b1, 32'hA5A5A5A5, 4'h3, 0, 32'h0, 1'b0, 0, 1'b0);
    tmo_clr_i = 1'b1; tmo_exp = 1'b0; tmo_port_exp = 2'd0;
    @(negedge clk);
    tmo_clr_i = 1'b0;
    check_eq("tmo_cleared", {tmo_port_o, tmo_o}, 3'b000);
    run_txn(32'h3000, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0, TMO, 1'b0);
    base_m[0] = 32'h2000;
    run_txn(32'h2000, 1'b0, 32'h0, 4'h0, TMO, 32'h0BADF00D, 1'b1, 0, 1'b1);
    base_m[0] = 32'h1000;
    drive_map();

    // reset while forwarding
    in_valid_i = 1'b1; in_addr_i = 32'h2004; in_write_i = 1'b0; out_ready_i = 4'b0000;
    repeat (3) @(negedge clk);
    in_valid_i = 1'b0;
    check_eq("fwd_before_rst", out_valid_o, 4'b0010);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    tmo_exp = 1'b0; tmo_port_exp = 2'd0;
    check_eq("rst_fwd_valid", out_valid_o, 4'b0000);
    check_eq("rst_fwd_ready", in_ready_o, 1'b0);
    run_txn(32'h2008, 1'b0, 32'h0, 4'h0, 2, 32'h13572468, 1'b0, 0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      int clr;
      if (i % 10 == 0) begin
        for (int p = 0; p < NP; p++) begin
          base_m[p] = $urandom & 32'h0000FF00;
          mask_m[p] = ($urandom_range(0, 3) == 0) ? 32'h0000FF00 : 32'h0000F000;
        end
      end
      a   = $urandom & 32'h0000FFFF;
      clr = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TMO + 2) : 0;
      run_txn(a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, TMO + 2),
              $urandom, 1'($urandom), clr, 1'($urandom));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
